// File: rtl/hook_controller.sv
// Miner hook FSM: swings between angle limits, extends on fire, retracts with or without a load.
// Optional HOOK_DYNAMITE_EN adds a drop input that discards the load during retraction.
module hook_controller #(
   parameter int OFFSET_X     = 320,
   parameter int OFFSET_Y     = 96,
   parameter int LEN_W        = 10,
   parameter int MIN_LENGTH   = 16,
   parameter int MAX_LENGTH   = 400,
   parameter int ANGLE_MIN    = 132,
   parameter int ANGLE_MAX    = 250,
   parameter int ANGLE_START  = 192,
   parameter int SWING_DIV    = 4,
   parameter int EXTEND_STEP  = 4,
   parameter int RETRACT_STEP = 8,
   parameter int WEIGHT_W     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                start_of_frame,
   input  logic                fire,
   input  logic                hit,
   input  logic [WEIGHT_W-1:0] hit_weight,
   input  logic [7:0]          sin_mag,
   input  logic [7:0]          cos_mag,
   input  logic                sin_neg,
   input  logic                cos_neg,
`ifdef HOOK_DYNAMITE_EN
   input  logic                drop,
`endif
   output logic [7:0]          angle,
   output logic [LEN_W-1:0]    length,
   output logic [10:0]         tip_x,
   output logic [10:0]         tip_y,
   output logic [1:0]          state,
   output logic                grabbed,
   output logic                catch_valid,
   output logic [WEIGHT_W-1:0] catch_weight
);

   localparam int DIV_W = (SWING_DIV > 1) ? $clog2(SWING_DIV) : 1;

   localparam logic [1:0] ST_SWING   = 2'd0;
   localparam logic [1:0] ST_EXTEND  = 2'd1;
   localparam logic [1:0] ST_RETRACT = 2'd2;

   logic                tick;
   logic                dir_up;
   logic                fire_pending;
   logic [DIV_W-1:0]    divider;
   logic [WEIGHT_W-1:0] weight_q;
   logic                drop_now;
   logic                keep_load;

   logic [LEN_W:0]      ext_sum;
   logic                ext_at_max;
   logic [LEN_W-1:0]    ext_len;
   logic [LEN_W-1:0]    ret_shift;
   logic [LEN_W-1:0]    ret_step;
   logic [LEN_W:0]      ret_floor;
   logic                ret_done;

   logic [LEN_W+7:0]    prod_x;
   logic [LEN_W+7:0]    prod_y;
   logic [10:0]         dx;
   logic [10:0]         dy;

   assign tick = enable & start_of_frame;

`ifdef HOOK_DYNAMITE_EN
   assign drop_now = drop;
`else
   assign drop_now = 1'b0;
`endif

   // A dropped load retracts at full speed from the drop tick onward and is never delivered.
   assign keep_load = grabbed & ~drop_now;

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      ext_sum    = {1'b0, length} + (LEN_W+1)'(EXTEND_STEP);
      ext_at_max = (ext_sum >= (LEN_W+1)'(MAX_LENGTH));
      ext_len    = ext_at_max ? LEN_W'(MAX_LENGTH) : ext_sum[LEN_W-1:0];

      ret_shift = LEN_W'(RETRACT_STEP) >> weight_q;
      if (!keep_load)
         ret_step = LEN_W'(RETRACT_STEP);
      else if (ret_shift == '0)
         ret_step = LEN_W'(1);
      else
         ret_step = ret_shift;

      // Compare length <= MIN+step instead of length-step <= MIN so nothing underflows.
      ret_floor = (LEN_W+1)'(MIN_LENGTH) + {1'b0, ret_step};
      ret_done  = ({1'b0, length} <= ret_floor);
   end

   assign prod_x = (LEN_W+8)'(length) * (LEN_W+8)'(cos_mag);
   assign prod_y = (LEN_W+8)'(length) * (LEN_W+8)'(sin_mag);
   assign dx     = 11'(prod_x >> 8);
   assign dy     = 11'(prod_y >> 8);

   // Screen y grows downward, so a positive sine moves the tip up.
   assign tip_x = 11'(OFFSET_X) + (cos_neg ? -dx : dx);
   assign tip_y = 11'(OFFSET_Y) + (sin_neg ? dy : -dy);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         angle        <= 8'(ANGLE_START);
         dir_up       <= 1'b1;
         length       <= LEN_W'(MIN_LENGTH);
         state        <= ST_SWING;
         grabbed      <= 1'b0;
         weight_q     <= '0;
         catch_valid  <= 1'b0;
         catch_weight <= '0;
         divider      <= '0;
         fire_pending <= 1'b0;
      end else begin
         catch_valid <= 1'b0;

         if (enable && state == ST_SWING && fire)
            fire_pending <= 1'b1;

         if (tick) begin
            case (state)
               ST_SWING: begin
                  if (fire_pending) begin
                     state        <= ST_EXTEND;
                     divider      <= '0;
                     fire_pending <= 1'b0;
                  end else if (divider == DIV_W'(SWING_DIV - 1)) begin
                     divider <= '0;
                     if (dir_up && angle >= 8'(ANGLE_MAX)) begin
                        dir_up <= 1'b0;
                        angle  <= angle - 8'd1;
                     end else if (!dir_up && angle <= 8'(ANGLE_MIN)) begin
                        dir_up <= 1'b1;
                        angle  <= angle + 8'd1;
                     end else begin
                        angle  <= dir_up ? angle + 8'd1 : angle - 8'd1;
                     end
                  end else begin
                     divider <= divider + DIV_W'(1);
                  end
               end

               ST_EXTEND: begin
                  if (hit) begin
                     grabbed  <= 1'b1;
                     weight_q <= hit_weight;
                     state    <= ST_RETRACT;
                  end else begin
                     length <= ext_len;
                     if (ext_at_max)
                        state <= ST_RETRACT;
                  end
               end

               ST_RETRACT: begin
                  if (drop_now) begin
                     grabbed  <= 1'b0;
                     weight_q <= '0;
                  end
                  if (ret_done) begin
                     length   <= LEN_W'(MIN_LENGTH);
                     state    <= ST_SWING;
                     grabbed  <= 1'b0;
                     weight_q <= '0;
                     if (keep_load) begin
                        catch_valid  <= 1'b1;
                        catch_weight <= weight_q;
                     end
                  end else begin
                     length <= length - ret_step;
                  end
               end

               default: state <= ST_SWING;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hook_controller.sv
// Directed self-checking bench for hook_controller (default parameters).
// Define HOOK_DYNAMITE_EN for both files to also exercise the drop input.
module tb_hook_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        start_of_frame = 1'b0;
   logic        fire = 1'b0;
   logic        hit = 1'b0;
   logic [2:0]  hit_weight = 3'd0;
   logic [7:0]  sin_mag = 8'd255;
   logic [7:0]  cos_mag = 8'd128;
   logic        sin_neg = 1'b0;
   logic        cos_neg = 1'b0;
`ifdef HOOK_DYNAMITE_EN
   logic        drop = 1'b0;
`endif
   logic [7:0]  angle;
   logic [9:0]  length;
   logic [10:0] tip_x;
   logic [10:0] tip_y;
   logic [1:0]  state;
   logic        grabbed;
   logic        catch_valid;
   logic [2:0]  catch_weight;

   int total  = 0;
   int passed = 0;

   hook_controller dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .start_of_frame (start_of_frame),
      .fire           (fire),
      .hit            (hit),
      .hit_weight     (hit_weight),
      .sin_mag        (sin_mag),
      .cos_mag        (cos_mag),
      .sin_neg        (sin_neg),
      .cos_neg        (cos_neg),
`ifdef HOOK_DYNAMITE_EN
      .drop           (drop),
`endif
      .angle          (angle),
      .length         (length),
      .tip_x          (tip_x),
      .tip_y          (tip_y),
      .state          (state),
      .grabbed        (grabbed),
      .catch_valid    (catch_valid),
      .catch_weight   (catch_weight)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         start_of_frame = 1'b1;
         @(posedge clk);
         #1;
         start_of_frame = 1'b0;
      end
   endtask

   task automatic pulse_fire();
      fire = 1'b1;
      @(posedge clk);
      #1;
      fire = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      total++;
      if ({angle, length, state, grabbed, catch_valid, catch_weight} !==
          {8'd192, 10'd16, 2'd0, 1'b0, 1'b0, 3'd0})
         $display("FAIL reset_state: got angle=%0d len=%0d st=%0d grab=%0d cv=%0d cw=%0d required 192/16/0/0/0/0",
                  angle, length, state, grabbed, catch_valid, catch_weight);
      else passed++;
      total++;
      if ({tip_x, tip_y} !== {11'd328, 11'd81})
         $display("FAIL tip_pos: got x=%0d y=%0d required x=328 y=81", tip_x, tip_y);
      else passed++;
      cos_neg = 1'b1;
      sin_neg = 1'b1;
      #1;
      total++;
      if ({tip_x, tip_y} !== {11'd312, 11'd111})
         $display("FAIL tip_neg: got x=%0d y=%0d required x=312 y=111", tip_x, tip_y);
      else passed++;
      cos_neg = 1'b0;
      sin_neg = 1'b0;
   endtask

   task automatic test_swing();
      tick_n(3);
      total++;
      if (angle !== 8'd192) $display("FAIL swing_3_ticks: got %0d required 192", angle); else passed++;
      tick_n(1);
      total++;
      if (angle !== 8'd193) $display("FAIL swing_4_ticks: got %0d required 193", angle); else passed++;
      tick_n(4);
      total++;
      if ({angle, length, state} !== {8'd194, 10'd16, 2'd0})
         $display("FAIL swing_8_ticks: got angle=%0d len=%0d st=%0d required 194/16/0", angle, length, state);
      else passed++;
      // Disabled: frame strobes and fire must have no effect.
      enable = 1'b0;
      fire   = 1'b1;
      tick_n(8);
      fire   = 1'b0;
      enable = 1'b1;
      total++;
      if ({angle, state} !== {8'd194, 2'd0})
         $display("FAIL freeze: got angle=%0d st=%0d required 194/0", angle, state);
      else passed++;
      tick_n(4);
      total++;
      if ({angle, state} !== {8'd195, 2'd0})
         $display("FAIL after_freeze: got angle=%0d st=%0d required 195/0", angle, state);
      else passed++;
   endtask

   task automatic test_swing_limits();
      tick_n(220);
      total++;
      if (angle !== 8'd250) $display("FAIL reach_max: got %0d required 250", angle); else passed++;
      tick_n(4);
      total++;
      if (angle !== 8'd249) $display("FAIL bounce_max: got %0d required 249", angle); else passed++;
      tick_n(468);
      total++;
      if (angle !== 8'd132) $display("FAIL reach_min: got %0d required 132", angle); else passed++;
      tick_n(4);
      total++;
      if (angle !== 8'd133) $display("FAIL bounce_min: got %0d required 133", angle); else passed++;
   endtask

   task automatic test_extend_empty();
      bit saw_catch = 1'b0;
      tick_n(268);
      total++;
      if (angle !== 8'd200) $display("FAIL aim_200: got %0d required 200", angle); else passed++;
      pulse_fire();
      tick_n(1);
      total++;
      if ({state, length, angle} !== {2'd1, 10'd16, 8'd200})
         $display("FAIL enter_extend: got st=%0d len=%0d angle=%0d required 1/16/200", state, length, angle);
      else passed++;
      tick_n(1);
      total++;
      if (length !== 10'd20) $display("FAIL extend_first: got %0d required 20", length); else passed++;
      pulse_fire();  // ignored outside SWING
      tick_n(94);
      total++;
      if ({state, length} !== {2'd1, 10'd396})
         $display("FAIL extend_396: got st=%0d len=%0d required 1/396", state, length);
      else passed++;
      tick_n(1);
      total++;
      if ({state, length} !== {2'd2, 10'd400})
         $display("FAIL extend_max: got st=%0d len=%0d required 2/400", state, length);
      else passed++;
      cos_mag = 8'd255;
      cos_neg = 1'b1;
      #1;
      total++;
      if ({tip_x, tip_y} !== {11'd1970, 11'd1746})
         $display("FAIL tip_wrap: got x=%0d y=%0d required x=1970 y=1746", tip_x, tip_y);
      else passed++;
      cos_mag = 8'd128;
      cos_neg = 1'b0;
      tick_n(1);
      total++;
      if (length !== 10'd392) $display("FAIL retract_empty_step: got %0d required 392", length); else passed++;
      for (int i = 0; i < 47; i++) begin
         tick_n(1);
         saw_catch |= catch_valid;
      end
      total++;
      if ({state, length, grabbed, saw_catch, angle} !== {2'd0, 10'd16, 1'b0, 1'b0, 8'd200})
         $display("FAIL retract_empty_done: got st=%0d len=%0d grab=%0d catch=%0d angle=%0d required 0/16/0/0/200",
                  state, length, grabbed, saw_catch, angle);
      else passed++;
      tick_n(1);
      total++;
      if (state !== 2'd0) $display("FAIL fire_ignored: got st=%0d required 0", state); else passed++;
   endtask

   task automatic test_hit_catch();
      pulse_fire();
      tick_n(22);
      total++;
      if ({state, length} !== {2'd1, 10'd100})
         $display("FAIL extend_100: got st=%0d len=%0d required 1/100", state, length);
      else passed++;
      hit        = 1'b1;
      hit_weight = 3'd2;
      tick_n(1);
      total++;
      if ({state, length, grabbed} !== {2'd2, 10'd100, 1'b1})
         $display("FAIL grab: got st=%0d len=%0d grab=%0d required 2/100/1", state, length, grabbed);
      else passed++;
      hit_weight = 3'd5;  // weight is latched; hit ignored while retracting
      tick_n(1);
      hit = 1'b0;
      total++;
      if ({state, length} !== {2'd2, 10'd98})
         $display("FAIL loaded_step: got st=%0d len=%0d required 2/98", state, length);
      else passed++;
      tick_n(40);
      total++;
      if ({state, length, catch_valid} !== {2'd2, 10'd18, 1'b0})
         $display("FAIL loaded_41: got st=%0d len=%0d cv=%0d required 2/18/0", state, length, catch_valid);
      else passed++;
      tick_n(1);
      total++;
      if ({state, length, grabbed, catch_valid, catch_weight} !== {2'd0, 10'd16, 1'b0, 1'b1, 3'd2})
         $display("FAIL catch: got st=%0d len=%0d grab=%0d cv=%0d cw=%0d required 0/16/0/1/2",
                  state, length, grabbed, catch_valid, catch_weight);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if ({catch_valid, catch_weight} !== {1'b0, 3'd2})
         $display("FAIL catch_pulse_width: got cv=%0d cw=%0d required 0/2", catch_valid, catch_weight);
      else passed++;
   endtask

   task automatic test_hit_at_max();
      pulse_fire();
      tick_n(96);
      total++;
      if ({state, length} !== {2'd1, 10'd396})
         $display("FAIL near_max: got st=%0d len=%0d required 1/396", state, length);
      else passed++;
      hit        = 1'b1;
      hit_weight = 3'd7;
      tick_n(1);
      hit = 1'b0;
      total++;
      if ({state, length, grabbed} !== {2'd2, 10'd396, 1'b1})
         $display("FAIL hit_beats_max: got st=%0d len=%0d grab=%0d required 2/396/1", state, length, grabbed);
      else passed++;
      tick_n(1);
      total++;
      if (length !== 10'd395) $display("FAIL min_step_1: got %0d required 395", length); else passed++;
   endtask

   task automatic test_reset_mid_retract();
      bit saw_catch = 1'b0;
      tick_n(2);
      pulse_reset();
      total++;
      if ({angle, length, state, grabbed, catch_valid, catch_weight} !==
          {8'd192, 10'd16, 2'd0, 1'b0, 1'b0, 3'd0})
         $display("FAIL reset_mid_retract: got angle=%0d len=%0d st=%0d grab=%0d cv=%0d cw=%0d required 192/16/0/0/0/0",
                  angle, length, state, grabbed, catch_valid, catch_weight);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         tick_n(1);
         saw_catch |= catch_valid;
      end
      total++;
      if ({angle, state, saw_catch} !== {8'd193, 2'd0, 1'b0})
         $display("FAIL post_reset_swing: got angle=%0d st=%0d catch=%0d required 193/0/0", angle, state, saw_catch);
      else passed++;
   endtask

`ifdef HOOK_DYNAMITE_EN
   task automatic test_dynamite();
      pulse_fire();
      tick_n(22);
      hit        = 1'b1;
      hit_weight = 3'd3;
      tick_n(1);
      hit = 1'b0;
      tick_n(1);
      total++;
      if ({grabbed, length} !== {1'b1, 10'd99})
         $display("FAIL dyn_loaded: got grab=%0d len=%0d required 1/99", grabbed, length);
      else passed++;
      drop = 1'b1;
      tick_n(1);
      drop = 1'b0;
      total++;
      if ({state, grabbed, length} !== {2'd2, 1'b0, 10'd91})
         $display("FAIL dyn_drop: got st=%0d grab=%0d len=%0d required 2/0/91", state, grabbed, length);
      else passed++;
      tick_n(9);
      total++;
      if (length !== 10'd19) $display("FAIL dyn_fast: got %0d required 19", length); else passed++;
      tick_n(1);
      total++;
      if ({state, length, catch_valid} !== {2'd0, 10'd16, 1'b0})
         $display("FAIL dyn_no_catch: got st=%0d len=%0d cv=%0d required 0/16/0", state, length, catch_valid);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_swing();
      test_swing_limits();
      test_extend_empty();
      test_hit_catch();
      test_hit_at_max();
      test_reset_mid_retract();
`ifdef HOOK_DYNAMITE_EN
      test_dynamite();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
